// File: rtl/logos_mem_pkg.sv
// Shared constants for the memory arbiter family.
// Arbitration mode encodings, DMA port index and default widths.
package logos_mem_pkg;

   localparam int PRIO_RR        = 0;
   localparam int PRIO_DMA_FIRST = 1;

   localparam int DMA_PORT = 0;

   localparam int DEF_NUM_PORTS = 3;
   localparam int DEF_ADDR_W    = 64;
   localparam int DEF_DATA_W    = 64;
   localparam int DEF_MAX_OUT   = 4;
   localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/mem_arbiter_n_tag_fifo.sv
// Outstanding-read tag FIFO: holds the port index of each read in flight.
// Depth is a power of two; depth 1 keeps both pointers pinned at zero.
module tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (DEPTH == 1) ? '0 : p + 1'b1;
   endfunction

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = bump(wr_ptr_q);
      if (pop)  rd_ptr_d = bump(rd_ptr_q);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push) mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: round-robin or DMA-first selection onto one
// memory port, in-order read routing via a tag FIFO, per-port counters.
module mem_arbiter_n
   import logos_mem_pkg::*;
#(
   parameter int NUM_PORTS       = DEF_NUM_PORTS,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUT,
   parameter int PRIO_MODE       = PRIO_RR,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          gnt,
   output logic [NUM_PORTS-1:0]          valid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_gnt,
   input  logic                          mem_valid,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [NUM_PORTS*CNT_W-1:0]    perf_gnt,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                          err_orphan
);

   localparam int TW = $clog2(NUM_PORTS);
   localparam bit DMA_FIRST = (PRIO_MODE == PRIO_DMA_FIRST);
   localparam logic [TW-1:0] RR_BASE = DMA_FIRST ? TW'(1) : '0;
   localparam logic [TW-1:0] LAST    = TW'(NUM_PORTS - 1);

   logic [TW-1:0]        rr_ptr_q, rr_ptr_d;
   logic                 err_orphan_q, err_orphan_d;
   logic [CNT_W-1:0]     perf_q [NUM_PORTS];
   logic [CNT_W-1:0]     perf_d [NUM_PORTS];

   logic [NUM_PORTS-1:0] elig;
   logic [TW-1:0]        sel, idx;
   logic                 any_sel, accept;
   logic                 fifo_push, fifo_pop;
   logic                 fifo_full, fifo_empty;
   logic [TW-1:0]        fifo_head;

   // Full is registered state, so a pop this cycle cannot admit a read.
   assign elig = req & (we | {NUM_PORTS{~fifo_full}});

   always_comb begin
      any_sel = 1'b0;
      sel     = '0;
      idx     = '0;
      if (DMA_FIRST && elig[DMA_PORT]) begin
         any_sel = 1'b1;
         sel     = TW'(DMA_PORT);
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (DMA_FIRST)
               idx = TW'(1 + (int'(rr_ptr_q) - 1 + k) % (NUM_PORTS - 1));
            else
               idx = TW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!any_sel && elig[idx]) begin
               any_sel = 1'b1;
               sel     = idx;
            end
         end
      end
   end

   assign mem_req   = any_sel;
   assign mem_we    = we[sel];
   assign mem_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
   assign mem_wdata = wdata[int'(sel)*DATA_W +: DATA_W];
   assign accept    = any_sel & mem_gnt;
   assign fifo_push = accept & ~mem_we;
   assign fifo_pop  = mem_valid & ~fifo_empty;
   assign rdata     = mem_rdata;
   assign err_orphan = err_orphan_q;

   always_comb begin
      gnt   = '0;
      valid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         gnt[i]   = accept && (sel == TW'(i));
         valid[i] = fifo_pop && (fifo_head == TW'(i));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         if (DMA_FIRST && sel == TW'(DMA_PORT))
            rr_ptr_d = rr_ptr_q;
         else if (sel == LAST)
            rr_ptr_d = RR_BASE;
         else
            rr_ptr_d = sel + 1'b1;
      end
   end

   always_comb begin
      err_orphan_d = err_orphan_q | (mem_valid & fifo_empty);
      perf_gnt     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         perf_d[i] = perf_q[i];
         if (gnt[i] && perf_q[i] != '1)
            perf_d[i] = perf_q[i] + 1'b1;
         perf_gnt[i*CNT_W +: CNT_W] = perf_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q     <= RR_BASE;
         err_orphan_q <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) perf_q[i] <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         err_orphan_q <= err_orphan_d;
         for (int i = 0; i < NUM_PORTS; i++) perf_q[i] <= perf_d[i];
      end
   end

   tag_fifo #(
      .W     (TW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (fifo_push),
      .din   (sel),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

endmodule
